freq_meter: RTL

Measures the frequency of an external square wave (microphone comparator, loop-back of the speaker line, or any tone source) by gated edge counting and exposes the result on an Avalon-MM read slave. It is the read-side counterpart of the tone generator: software writes a frequency in Hz to the generator and reads a frequency in Hz back from this block. It sits on the same Avalon bus and clock domain as the generator.

---
 rtl/freq_meter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter with an Avalon-MM read slave (FREQ / STATUS).
// Optional glitch filter on the conditioned input: define FREQ_METER_GLITCH_FILTER_EN.
module freq_meter #(
    parameter int unsigned fclk        = 50_000_000,
    parameter int unsigned GATE_HZ     = 10,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sig_in,
    input  logic        address,
    input  logic        read,
    output logic [31:0] readdata
);

    localparam int unsigned GATE_CYCLES = fclk / GATE_HZ;
    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    // Input conditioning
    logic sync1_q, sync2_q;
    logic s, s_prev_q, edge_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef FREQ_METER_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;

    // s only follows the synchronized level once it has differed for FILT_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b0;
        end else if (sync2_q == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q >= FILT_LAST) begin
            filt_cnt_q <= '0;
            filt_q     <= sync2_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign s = filt_q;
`else
    localparam int unsigned unused_filt_cycles = FILT_CYCLES;

    assign s = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s;
        end
    end

    assign edge_now = s & ~s_prev_q;

    // Gate / edge counting and result registers
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic [31:0]   edge_cnt_q, edge_cnt_d;
    logic [31:0]   freq_q, freq_d;
    logic          new_q, new_d;
    logic          ovf_q, ovf_d;
    logic          present_q, present_d;
    logic [31:0]   readdata_q, readdata_d;

    logic          gate_end;
    logic [32:0]   edge_sum;
    logic [65:0]   freq_wide;
    logic          freq_sat;
    logic          new_set, ovf_set;
    logic          rd_freq, rd_status;
    logic [31:0]   status;

    assign gate_end  = (gate_cnt_q == GATE_LAST);
    // The closing gate includes an edge detected in its final cycle.
    assign edge_sum  = {1'b0, edge_cnt_q} + {32'd0, edge_now};
    assign freq_wide = {33'd0, edge_sum} * 66'(GATE_HZ);
    assign freq_sat  = |freq_wide[65:32];
    assign rd_freq   = read & ~address;
    assign rd_status = read & address;
    assign status    = {29'd0, present_q, ovf_q, new_q};

    always_comb begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = edge_cnt_q;
        freq_d     = freq_q;
        present_d  = present_q;
        new_set    = 1'b0;
        ovf_set    = 1'b0;
        readdata_d = readdata_q;

        if (gate_end) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            freq_d     = freq_sat ? 32'hFFFF_FFFF : freq_wide[31:0];
            ovf_set    = freq_sat;
            new_set    = 1'b1;
            present_d  = |edge_sum;
        end else if (edge_now) begin
            if (&edge_cnt_q) begin
                ovf_set = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 32'd1;
            end
        end

        // Flag sets take priority over read-side clears.
        new_d = new_set | (new_q & ~rd_freq);
        ovf_d = ovf_set | (ovf_q & ~rd_status);

        if (read) begin
            readdata_d = address ? status : freq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            new_q      <= 1'b0;
            ovf_q      <= 1'b0;
            present_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            new_q      <= new_d;
            ovf_q      <= ovf_d;
            present_q  <= present_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
